caliptra_apb_requester: RTL and testbench
=========================================

Name: caliptra_apb_requester

Overview:
- Single-outstanding APB4 initiator (requester).
- Converts a valid/ready request channel into APB setup and access phases, and returns read data or error status on a valid/ready response channel.
- Drives the APB slave ports of the Caliptra and MCU wrappers, for FPGA-side register access and for bench stimulus.
- Includes a wait-state timeout so a hung PREADY cannot stall the requester.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and PADDR.
- DATA_WIDTH, 32, width of APB data; PSTRB width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycles without PREADY before abort; 0 disables the timeout.

Ports:
- core_clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  DATA_WIDTH/8  write byte strobes.
- req_prot  in  3  PPROT value.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_slverr  out  1  PSLVERR sampled, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  ADDR_WIDTH  APB address.
- PPROT  out  3  APB protection.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  DATA_WIDTH/8  APB write strobes.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY, PSLVERR  in  1 each  APB completer response.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state IDLE, timeout counter 0.
- State machine:
  - IDLE → SETUP, when req_valid && req_ready.
  - SETUP → ACCESS, unconditionally after 1 cycle.
  - ACCESS → RESP, on PREADY or timeout.
  - RESP → IDLE, on rsp_ready.
- req_ready = 1 only in IDLE. Requests are never accepted in any other state.
- On accept (cycle T):
  - Capture write, addr, wdata, strb, prot.
  - PADDR = {req_addr[ADDR_WIDTH-1:2], 2'b00}.
  - PSTRB = req_strb for writes, 0 for reads (APB4 rule).
- T+1 (SETUP): PSEL=1, PENABLE=0; PADDR, PWRITE, PWDATA, PSTRB, PPROT valid.
- T+2 onward (ACCESS):
  - PSEL=1, PENABLE=1.
  - Address, control and data held stable until PREADY.
  - Wait counter increments each ACCESS cycle with PREADY=0.
- On the ACCESS cycle where PREADY=1:
  - Next cycle: PSEL=0, PENABLE=0, state RESP, rsp_valid=1.
  - rsp_rdata = PRDATA for reads, 0 for writes.
  - rsp_slverr = PSLVERR; rsp_timeout = 0.
- Timeout (TIMEOUT_CYCLES > 0):
  - Triggers when the counter reaches TIMEOUT_CYCLES with PREADY still 0.
  - Next cycle: PSEL and PENABLE drop, state RESP, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
  - If PREADY=1 on the same cycle the counter hits the limit, PREADY wins: normal completion, no timeout.
- RESP:
  - rsp_valid and all rsp_* fields held stable until rsp_ready.
  - The cycle after rsp_ready: rsp_valid=0, state IDLE, req_ready=1.
- Throughput:
  - Minimum 4 cycles per transfer: accept, SETUP, ACCESS, RESP with rsp_ready=1.
  - PSEL is never held across transfers; there is always at least one idle APB cycle between transfers.
- Idle APB bus: PADDR, PWDATA, PWRITE, PPROT, PSTRB hold their last values; PSEL=PENABLE=0.
- PSLVERR and PRDATA are sampled only when PSEL && PENABLE && PREADY.
- Reset mid-transfer:
  - Next edge forces the full reset state: PSEL and PENABLE drop, no response is issued, the in-flight request is discarded.
- Wait counter:
  - Width $clog2(TIMEOUT_CYCLES+1), minimum 1.
  - Cleared on entering SETUP.
  - Never wraps.

Test Plan:
- Zero-wait write: addr 0x0000_0110, wdata 0xA5A5_0001, strb 0xF, completer PREADY=1 immediately.
  → PSEL rises T+1, PENABLE T+2; rsp_valid at T+3 with slverr=0, rdata=0; req_ready again at T+4.
- Read with 3 wait states: addr 0x0000_0004, PRDATA=0x1234_5678 on the PREADY cycle.
  → PENABLE high for 4 cycles, PSTRB=0; rsp_rdata=0x1234_5678.
- Error response: read with PSLVERR=1 and PREADY=1.
  → rsp_slverr=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=8, PREADY held 0.
  → PSEL drops after 8 ACCESS cycles; rsp_slverr=1, rsp_timeout=1, rdata=0. A subsequent normal read completes correctly.
- Response backpressure and unaligned address: rsp_ready held 0 for 5 cycles, req_valid held high with next request, req_addr=0x13.
  → rsp fields stable; req_ready stays 0 until the cycle after rsp_ready; PADDR=0x10.
- Reset in ACCESS (PREADY=0), rst pulsed for 1 cycle.
  → next cycle all outputs 0, no rsp_valid, req_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/caliptra_apb_requester_if.sv
// Request/response channel plus APB4 bus seen by the requester.
// master = requester side, slave = client/completer side.
interface caliptra_apb_requester_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [SW-1:0]         req_strb;
  logic [2:0]            req_prot;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_slverr;
  logic                  rsp_timeout;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [2:0]            PPROT;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [SW-1:0]         PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  req_strb, req_prot, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_slverr, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR,
    output PPROT, PWDATA, PSTRB
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output req_strb, req_prot, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_slverr, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR,
    input  PPROT, PWDATA, PSTRB
  );
endinterface

// File: rtl/caliptra_apb_requester.sv
// Single-outstanding APB4 requester with wait-state timeout.
// All outputs come straight from registers.
module caliptra_apb_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic core_clk,
  input logic rst,
  caliptra_apb_requester_if.master bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_tmo_q, rsp_tmo_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [2:0]            pprot_q, pprot_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic                  done;
  logic                  tmo_hit;

  assign done    = psel_q && penable_q && bus.PREADY;
  // The count-th stalled cycle is the last one; PREADY still wins on it.
  assign tmo_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == LIMIT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
    rsp_tmo_d    = rsp_tmo_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pprot_d      = pprot_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          state_d  = SETUP;
          cnt_d    = '0;
          psel_d   = 1'b1;
          pwrite_d = bus.req_write;
          paddr_d  = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
          pprot_d  = bus.req_prot;
          pwdata_d = bus.req_wdata;
          pstrb_d  = bus.req_write ? bus.req_strb : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (done) begin
          state_d      = RESP;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = pwrite_q ? '0 : bus.PRDATA;
          rsp_slverr_d = bus.PSLVERR;
          rsp_tmo_d    = 1'b0;
        end else if (tmo_hit) begin
          state_d      = RESP;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = '0;
          rsp_slverr_d = 1'b1;
          rsp_tmo_d    = 1'b1;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
      rsp_tmo_q    <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pprot_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
      rsp_tmo_q    <= rsp_tmo_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pprot_q      <= pprot_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_slverr  = rsp_slverr_q;
  assign bus.rsp_timeout = rsp_tmo_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PPROT       = pprot_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
endmodule

// File: tb/tb_caliptra_apb_requester.sv
// Bench for caliptra_apb_requester: per-transfer expected trace
// built from the transfer timing rules, checked every cycle.
module tb_caliptra_apb_requester;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  caliptra_apb_requester_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  caliptra_apb_requester #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .core_clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        psel, pen, pwrite, rv, rr;
    logic        slverr, tmo, bus_chk;
    logic [31:0] paddr, pwdata, rdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } snap_t;

  snap_t exp_q[int];
  snap_t log_a[int];
  int cyc = 0;
  int vec = 0;
  int bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h expected %h",
               nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    snap_t a, e;
    a.psel    = bus.PSEL;
    a.pen     = bus.PENABLE;
    a.pwrite  = bus.PWRITE;
    a.rv      = bus.rsp_valid;
    a.rr      = bus.req_ready;
    a.slverr  = bus.rsp_slverr;
    a.tmo     = bus.rsp_timeout;
    a.bus_chk = 1'b1;
    a.paddr   = bus.PADDR;
    a.pwdata  = bus.PWDATA;
    a.rdata   = bus.rsp_rdata;
    a.pstrb   = bus.PSTRB;
    a.pprot   = bus.PPROT;
    log_a[cyc] = a;
    if (exp_q.exists(cyc)) begin
      e = exp_q[cyc];
      chk("PSEL", 32'(a.psel), 32'(e.psel));
      chk("PENABLE", 32'(a.pen), 32'(e.pen));
      chk("rsp_valid", 32'(a.rv), 32'(e.rv));
      chk("req_ready", 32'(a.rr), 32'(e.rr));
      if (e.bus_chk) begin
        chk("PADDR", a.paddr, e.paddr);
        chk("PWRITE", 32'(a.pwrite), 32'(e.pwrite));
        chk("PWDATA", a.pwdata, e.pwdata);
        chk("PSTRB", 32'(a.pstrb), 32'(e.pstrb));
        chk("PPROT", 32'(a.pprot), 32'(e.pprot));
      end
      if (e.rv) begin
        chk("rsp_rdata", a.rdata, e.rdata);
        chk("rsp_slverr", 32'(a.slverr), 32'(e.slverr));
        chk("rsp_timeout", 32'(a.tmo), 32'(e.tmo));
      end
      exp_q.delete(cyc);
    end
  end

  // waits >= TO means the completer never answers.
  task automatic xfer(input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic [3:0] strb,
                      input logic [2:0] prot, input int waits,
                      input logic [31:0] prdata, input bit err,
                      input int rdly, input bit hold,
                      output int A, output int last);
    int n_acc, k;
    bit tmo;
    snap_t e;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (bus.req_ready !== 1'b1) begin
      chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
      A = -1;
      last = 0;
      return;
    end
    A = cyc;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    bus.req_prot  = prot;
    tmo   = (waits >= TO);
    n_acc = tmo ? TO : waits + 1;
    last  = 3 + n_acc + rdly;
    for (int j = 1; j <= last; j++) begin
      e = '{default: '0};
      e.bus_chk = 1'b1;
      e.paddr   = {addr[31:2], 2'b00};
      e.pwrite  = wr;
      e.pwdata  = wdata;
      e.pstrb   = wr ? strb : 4'h0;
      e.pprot   = prot;
      e.psel    = (j <= 1 + n_acc);
      e.pen     = (j >= 2) && (j <= 1 + n_acc);
      e.rv      = (j >= 2 + n_acc) && (j <= 2 + n_acc + rdly);
      e.rr      = (j == last);
      e.rdata   = (tmo || wr) ? 32'h0 : prdata;
      e.slverr  = tmo | err;
      e.tmo     = tmo;
      exp_q[A + j] = e;
    end
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      if (j == 1) begin
        if (hold) begin
          bus.req_write = 1'b0;
          bus.req_addr  = 32'h20;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      bus.PREADY    = !tmo && (j == 2 + waits);
      bus.PRDATA    = bus.PREADY ? prdata : ~prdata;
      bus.PSLVERR   = bus.PREADY ? err : ~err;
      bus.rsp_ready = (j == 2 + n_acc + rdly);
    end
  endtask

  function automatic int pen_cnt(input int A, input int n);
    int c = 0;
    for (int j = 1; j < n; j++)
      if (log_a.exists(A + j) && log_a[A + j].pen) c++;
    return c;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, "_psel"}, 32'(bus.PSEL), 32'd0);
    chk({nm, "_pen"}, 32'(bus.PENABLE), 32'd0);
    chk({nm, "_pwrite"}, 32'(bus.PWRITE), 32'd0);
    chk({nm, "_paddr"}, bus.PADDR, 32'd0);
    chk({nm, "_pwdata"}, bus.PWDATA, 32'd0);
    chk({nm, "_pstrb"}, 32'(bus.PSTRB), 32'd0);
    chk({nm, "_pprot"}, 32'(bus.PPROT), 32'd0);
    chk({nm, "_rv"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, "_rr"}, 32'(bus.req_ready), 32'd0);
    chk({nm, "_rdata"}, bus.rsp_rdata, 32'd0);
    chk({nm, "_slverr"}, 32'(bus.rsp_slverr), 32'd0);
    chk({nm, "_tmo"}, 32'(bus.rsp_timeout), 32'd0);
  endtask

  initial begin
    int A, L;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.req_prot  = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("reset_release_rr", 32'(bus.req_ready), 32'd1);

    // zero-wait write
    xfer(1, 32'h110, 32'hA5A5_0001, 4'hF, 3'd0, 0,
         32'h0, 0, 0, 0, A, L);
    chk("wr_psel_T1", 32'(log_a[A + 1].psel), 32'd1);
    chk("wr_pen_T1", 32'(log_a[A + 1].pen), 32'd0);
    chk("wr_pen_T2", 32'(log_a[A + 2].pen), 32'd1);
    chk("wr_paddr", log_a[A + 1].paddr, 32'h110);
    chk("wr_rv_T3", 32'(log_a[A + 3].rv), 32'd1);
    chk("wr_rdata", log_a[A + 3].rdata, 32'h0);
    chk("wr_rr_T4", 32'(bus.req_ready), 32'd1);

    // read, 3 wait states
    xfer(0, 32'h4, 32'h0, 4'hF, 3'd2, 3,
         32'h1234_5678, 0, 0, 0, A, L);
    chk("rd3_pen_cycles", 32'(pen_cnt(A, L)), 32'd4);
    chk("rd3_pstrb", 32'(log_a[A + 1].pstrb), 32'd0);
    chk("rd3_rdata", log_a[A + 6].rdata, 32'h1234_5678);

    // error response
    xfer(0, 32'h8, 32'h0, 4'h0, 3'd0, 0,
         32'hDEAD_BEEF, 1, 0, 0, A, L);
    chk("err_slverr", 32'(log_a[A + 3].slverr), 32'd1);
    chk("err_tmo", 32'(log_a[A + 3].tmo), 32'd0);

    // timeout, then a normal read
    xfer(0, 32'hC, 32'h0, 4'h0, 3'd1, TO,
         32'h7777_7777, 0, 0, 0, A, L);
    chk("to_pen_cycles", 32'(pen_cnt(A, L)), 32'd8);
    chk("to_tmo", 32'(log_a[A + 10].tmo), 32'd1);
    chk("to_slverr", 32'(log_a[A + 10].slverr), 32'd1);
    chk("to_rdata", log_a[A + 10].rdata, 32'h0);
    xfer(0, 32'h14, 32'h0, 4'h0, 3'd0, 1,
         32'hCAFE_F00D, 0, 0, 0, A, L);

    // PREADY on the last allowed cycle wins
    xfer(0, 32'h18, 32'h0, 4'h0, 3'd0, TO - 1,
         32'h0BAD_F00D, 0, 0, 0, A, L);
    chk("edge_tmo", 32'(log_a[A + 10].tmo), 32'd0);
    chk("edge_rdata", log_a[A + 10].rdata, 32'h0BAD_F00D);

    // backpressure + unaligned, next request held pending
    xfer(1, 32'h13, 32'h1122_3344, 4'h5, 3'd5, 0,
         32'h0, 0, 5, 1, A, L);
    chk("bp_paddr", log_a[A + 1].paddr, 32'h10);
    chk("bp_rv_held", 32'(log_a[A + 8].rv), 32'd1);
    chk("bp_rr_held", 32'(log_a[A + 8].rr), 32'd0);
    xfer(0, 32'h20, 32'h0, 4'h0, 3'd0, 0,
         32'h55AA_55AA, 0, 0, 0, A, L);

    // reset while stalled in ACCESS
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h40;
    bus.req_prot  = 3'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_pen", 32'(bus.PENABLE), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rr", 32'(bus.req_ready), 32'd1);
    chk("rst_mid_rv", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid_psel", 32'(bus.PSEL), 32'd0);

    xfer(0, 32'h30, 32'h0, 4'h0, 3'd3, 2,
         32'h0F0F_1234, 0, 1, 0, A, L);
    repeat (3) @(negedge clk);
    chk("trace_drained", 32'(exp_q.num()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end
endmodule
